// File: rtl/pipes_pkg.sv
// Shared types for the memory-stage load/store path: op encoding,
// access-size codes and the load/store unit state machine encoding.
package pipes_pkg;

    localparam logic [1:0] MSIZE_B = 2'd0;
    localparam logic [1:0] MSIZE_H = 2'd1;
    localparam logic [1:0] MSIZE_W = 2'd2;

    // [3] store, [2] unsigned, [1:0] size
    typedef struct packed {
        logic       store;
        logic       uns;
        logic [1:0] size;
    } mem_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } mau_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling for dmem words: extracts and extends a byte/half
// for loads, and merges store data into the addressed lane(s) for RMW stores.
module mem_lane_align
    import pipes_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Load path: pick the addressed lane (byte k lives at word[31-8k -: 8]) and extend it
    always_comb begin
        w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
        case (i_off)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        case (i_size)
            MSIZE_B: o_load = i_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            MSIZE_H: o_load = i_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

    // Store path: replace the addressed lane(s) of the read word with store data
    always_comb begin
        o_merge = i_word;
        if (i_size == MSIZE_B) begin
            case (i_off)
                2'd0:    o_merge[31:24] = i_wdata[7:0];
                2'd1:    o_merge[23:16] = i_wdata[7:0];
                2'd2:    o_merge[15:8]  = i_wdata[7:0];
                default: o_merge[7:0]   = i_wdata[7:0];
            endcase
        end else if (i_size == MSIZE_H) begin
            if (i_off[1]) o_merge[15:0]  = i_wdata;
            else          o_merge[31:16] = i_wdata;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one request at a time over valid/ready,
// word accesses to a combinational-read / clocked-write dmem, RMW for
// sub-word stores, extended loads, and fault reporting without memory effect.
module mem_access_unit
    import pipes_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [3:0]        i_req_op,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_misalign,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    input  logic [31:0]       i_dmem_rdata
);

    mau_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [15:0]       r_wdata;
    logic [31:0]       r_wbuf, r_rdata;
    logic              r_misalign;
    mem_op_t           w_op;
    logic              w_fault;
    logic [31:0]       w_load, w_merge;

    assign w_op = mem_op_t'(i_req_op);

    // Fault detection on the incoming request; without checking, low bits are masked to the size
    always_comb begin
        w_fault = (w_op.size == 2'd3);
        w_addr  = i_req_addr;
        if (CHECK_ALIGN) begin
            if (w_op.size == MSIZE_H && i_req_addr[0])          w_fault = 1'b1;
            if (w_op.size == MSIZE_W && i_req_addr[1:0] != 2'b0) w_fault = 1'b1;
        end else begin
            if (w_op.size == MSIZE_H) w_addr[0]   = 1'b0;
            if (w_op.size == MSIZE_W) w_addr[1:0] = 2'b00;
        end
    end

    mem_lane_align u_align (
        .i_word  (i_dmem_rdata),
        .i_off   (r_addr[1:0]),
        .i_size  (r_size),
        .i_uns   (r_uns),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    // Next state and state-decoded outputs; the write enable is gated by reset
    // so a reset landing on the WRITE cycle never commits the store
    always_comb begin
        w_state_nxt  = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                o_dmem_addr = '0;
                if (i_req_valid) begin
                    if (w_fault)                  w_state_nxt = S_RESP;
                    else if (!w_op.store)         w_state_nxt = S_LOAD;
                    else if (w_op.size == MSIZE_W) w_state_nxt = S_WRITE;
                    else                          w_state_nxt = S_RMW_RD;
                end
            end
            S_LOAD:   w_state_nxt = S_RESP;
            S_RMW_RD: w_state_nxt = S_WRITE;
            S_WRITE: begin
                o_dmem_we   = i_reset_n;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus request latch, load capture and write buffer
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_size     <= 2'b0;
            r_uns      <= 1'b0;
            r_wdata    <= 16'h0;
            r_wbuf     <= 32'h0;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_addr     <= w_addr;
                    r_size     <= w_op.size;
                    r_uns      <= w_op.uns;
                    r_wdata    <= i_req_wdata[15:0];
                    r_wbuf     <= i_req_wdata;
                    r_rdata    <= 32'h0;
                    r_misalign <= w_fault;
                end
                S_LOAD:   r_rdata <= w_load;
                S_RMW_RD: r_wbuf  <= w_merge;
                default: ;
            endcase
        end
    end

    assign o_resp_rdata    = r_rdata;
    assign o_resp_misalign = r_misalign;
    assign o_dmem_wdata    = r_wbuf;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store unit sitting directly upstream of dmem in the memory stage. It takes one byte, half or word load/store request at a time over a valid/ready handshake and turns it into 32-bit word accesses on dmem's combinational-read, clocked-write port. Sub-word stores use read-modify-write, loads are sign/zero-extended, and misaligned accesses are reported without touching memory.

Parameters:
ADDR_W, 32, width of request and dmem address
CHECK_ALIGN, 1, 1 = flag misaligned half/word accesses; 0 = force-align them silently

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_op  in  4  mem_op_t: [3] store, [2] unsigned, [1:0] size (0 byte, 1 half, 2 word, 3 illegal)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_misalign  out  1  access faulted (misaligned or size 3); no memory effect
dmem_we  out  1  dmem write enable
dmem_addr  out  ADDR_W  word-aligned address (req_addr & ~3)
dmem_wdata  out  32  word to write
dmem_rdata  in  32  combinational read data from dmem

Behaviour:
- Byte order is big-endian to match dmem: byte at aligned+k is word[31-8k -: 8]; half at offset o (0 or 2) is word[31-8o -: 16].
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch op, addr, wdata. Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, or size 3) -> RESP with misalign=1. Else load -> LOAD; SW -> WRITE with wdata=req_wdata; SB/SH -> RMW_RD.
- LOAD: drive dmem_addr; capture extracted and extended dmem_rdata into resp_rdata; -> RESP.
- RMW_RD: drive dmem_addr; capture dmem_rdata with the addressed lane(s) replaced by req_wdata[7:0] or [15:0] into the write buffer; -> WRITE.
- WRITE: dmem_we = reset_n (gated so a reset cycle never writes); dmem_wdata = write buffer; -> RESP.
- RESP: resp_valid=1, outputs held stable until resp_ready; on resp_ready -> IDLE. No new request is accepted in the same cycle (req_ready=0 in RESP).
- Latency, accept edge = cycle N:
  - loads and SW: resp_valid from N+2.
  - SB/SH: from N+3.
  - faults: from N+1.
- dmem_we is 0 in every state except WRITE. dmem_addr holds the latched aligned address outside IDLE and is 0 in IDLE.
- Extension rules:
  - LB: sign-extend from bit 7. LBU: zero-extend.
  - LH: sign-extend from bit 15. LHU: zero-extend.
  - LW: as read.
  - Unsigned bit is ignored for stores and for LW.
- CHECK_ALIGN=0: low address bits are masked to the access size and misalign is never set, except for size 3, which is always a fault.
- Reset (reset_n low at an edge):
  - state -> IDLE; resp_valid, resp_misalign, resp_rdata, dmem_we, write buffer -> 0.
  - Any in-flight request is dropped with no response and no write, including when reset falls during WRITE.
- resp_rdata and resp_misalign are registered; req_ready and dmem_we are decoded from state.

Decomposition:
- Shared package (pipes): mem_op_t fields and size constants MSIZE_B/H/W, plus the mau_state_t enum.
- One sub-module, mem_lane_align: purely combinational byte/half extract and extend for loads, and lane merge for stores, shared by LOAD and RMW_RD.

Test Plan:
- dmem word@0x20=0x80FF7F01. LB 0x20 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080; LH 0x20 -> 0xFFFF80FF; LHU 0x22 -> 0x00007F01; LW 0x20 -> 0x80FF7F01. Each resp_valid exactly 2 cycles after accept.
- word@0x10=0x11223344. SB 0x11 wdata=0x000000AB -> dmem_we one cycle, word becomes 0x11AB3344, resp at N+3; SH 0x12 wdata 0xBEEF -> 0x11ABBEEF.
- SW 0x13 -> resp_misalign=1 at N+1, resp_rdata=0, dmem_we never asserted, memory unchanged; CHECK_ALIGN=0 build -> SW writes to 0x10.
- Backpressure: LW with resp_ready low for 3 cycles -> resp_valid, resp_rdata stable, req_ready=0 throughout; back-to-back requests issue one per completion.
- reset_n low during WRITE of an SB to 0x10 -> no dmem write (word still 0x11223344), resp_valid=0, req_ready=1 the cycle after reset releases.
- Random op/addr/data sequence of 1000 requests checked against a byte-array reference model of dmem.
